// File: rtl/pipe_reg_chain_pkg.sv
// Shared definitions for the pipe_reg_chain pipeline register slice.
// Holds the occupancy width helper, the bubble payload constant and a
// default-width stage record type.
package pipe_pkg;

  localparam int unsigned PIPE_WIDTH_DEFAULT = 32;

  // Payload carried by an empty stage; kept at zero so waveforms compare cleanly.
  localparam logic [PIPE_WIDTH_DEFAULT-1:0] PIPE_BUBBLE_DATA = '0;

  typedef struct packed {
    logic                          valid;
    logic [PIPE_WIDTH_DEFAULT-1:0] data;
  } pipe_stage_t;

  // Bits needed to count 0..stages valid entries.
  function automatic int unsigned occ_width(input int unsigned stages);
    return $clog2(stages + 1);
  endfunction

endpackage

// File: rtl/pipe_stage_reg.sv
// One pipeline stage register: valid flag plus payload.
// Update priority: flush, hold, bubble behind a held upstream stage, load.
// Also exports the next-state valid bit so the top can count occupancy
// in the same cycle the valid flags change.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_flush,
  input  logic             i_hold,
  input  logic             i_bubble,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid_nxt
);

  logic             r_valid;
  logic [WIDTH-1:0] r_data;
  logic             w_valid_nxt;
  logic [WIDTH-1:0] w_data_nxt;
  logic [WIDTH-1:0] w_bubble_data;

  assign w_bubble_data = {WIDTH{PIPE_BUBBLE_DATA[0]}};

  // Next-state mux in priority order; an invalid load never carries payload.
  always_comb begin
    w_valid_nxt = r_valid;
    w_data_nxt  = r_data;
    if (i_flush) begin
      w_valid_nxt = 1'b0;
      w_data_nxt  = w_bubble_data;
    end else if (i_hold) begin
      w_valid_nxt = r_valid;
      w_data_nxt  = r_data;
    end else if (i_bubble) begin
      w_valid_nxt = 1'b0;
      w_data_nxt  = w_bubble_data;
    end else begin
      w_valid_nxt = i_valid;
      w_data_nxt  = i_valid ? i_data : w_bubble_data;
    end
  end

  // Stage register with synchronous reset to an empty bubble.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_valid <= 1'b0;
      r_data  <= w_bubble_data;
    end else begin
      r_valid <= w_valid_nxt;
      r_data  <= w_data_nxt;
    end
  end

  assign o_valid     = r_valid;
  assign o_data      = r_data;
  assign o_valid_nxt = w_valid_nxt;

endmodule

// File: rtl/pipe_reg_chain.sv
// Parametrised chain of STAGES pipeline registers with uniform stall/flush.
// Stage 0 is the youngest (fed from i_data), stage STAGES-1 the oldest.
// A stall freezes its stage and everything upstream; the stage just
// downstream of a frozen one receives a bubble.
// Optional build macro PIPE_REG_CHAIN_BUBBLE_COLLAPSE_EN: a stall only
// blocks while the stalled stage (and the chain above it) holds valid data,
// so empty stages are overwritten and bubbles squeeze out.
module pipe_reg_chain
  import pipe_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic                              i_clk,
  input  logic                              i_rst,
  input  logic                              i_valid,
  input  logic [WIDTH-1:0]                  i_data,
  output logic                              o_ready,
  input  logic [STAGES-1:0]                 i_stall,
  input  logic [STAGES-1:0]                 i_flush,
  output logic [STAGES-1:0]                 o_valid,
  output logic [STAGES*WIDTH-1:0]           o_data,
  output logic [occ_width(STAGES)-1:0]      o_occupancy
);

  localparam int OCC_W = occ_width(STAGES);

  logic [STAGES-1:0] w_valid;
  logic [STAGES-1:0] w_valid_nxt;
  logic [STAGES-1:0] w_hold;
  logic [OCC_W-1:0]  w_occ_nxt;
  logic [OCC_W-1:0]  r_occupancy;

  // Hold chain, walked from the oldest stage down to stage 0.
  always_comb begin
    logic w_up;
    w_hold = '0;
    w_up   = 1'b0;
    for (int k = STAGES - 1; k >= 0; k--) begin
`ifdef PIPE_REG_CHAIN_BUBBLE_COLLAPSE_EN
      w_hold[k] = w_valid[k] & (i_stall[k] | w_up);
`else
      w_hold[k] = i_stall[k] | w_up;
`endif
      w_up = w_hold[k];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic             w_in_valid;
    logic [WIDTH-1:0] w_in_data;
    logic             w_bubble;

    if (k == 0) begin : g_head
      assign w_in_valid = i_valid;
      assign w_in_data  = i_data;
      assign w_bubble   = 1'b0;
    end else begin : g_body
      assign w_in_valid = w_valid[k-1];
      assign w_in_data  = o_data[(k-1)*WIDTH +: WIDTH];
      assign w_bubble   = w_hold[k-1];
    end

    pipe_stage_reg #(
      .WIDTH(WIDTH)
    ) u_stage (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_flush    (i_flush[k]),
      .i_hold     (w_hold[k]),
      .i_bubble   (w_bubble),
      .i_valid    (w_in_valid),
      .i_data     (w_in_data),
      .o_valid    (w_valid[k]),
      .o_data     (o_data[k*WIDTH +: WIDTH]),
      .o_valid_nxt(w_valid_nxt[k])
    );
  end

  // Popcount of the next-state valid vector.
  always_comb begin
    w_occ_nxt = '0;
    for (int k = 0; k < STAGES; k++) begin
      w_occ_nxt = w_occ_nxt + OCC_W'(w_valid_nxt[k]);
    end
  end

  // Occupancy register, updated on the same edge as the valid flags.
  always_ff @(posedge i_clk) begin
    if (i_rst) r_occupancy <= '0;
    else       r_occupancy <= w_occ_nxt;
  end

  assign o_valid     = w_valid;
  assign o_ready     = ~w_hold[0];
  assign o_occupancy = r_occupancy;

endmodule

// File: tb/tb_pipe_reg_chain.sv
// Self-checking bench for pipe_reg_chain (STAGES=4, WIDTH=32).
// Directed vector table followed by randomized traffic against a reference model.
module tb_pipe_reg_chain;

  localparam int S = 4;
  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst;
  logic           vin;
  logic [W-1:0]   din;
  logic           rdy;
  logic [S-1:0]   stall;
  logic [S-1:0]   flush;
  logic [S-1:0]   vout;
  logic [S*W-1:0] dout;
  logic [2:0]     occ;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pipe_reg_chain #(.WIDTH(W), .STAGES(S)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_valid    (vin),
    .i_data     (din),
    .o_ready    (rdy),
    .i_stall    (stall),
    .i_flush    (flush),
    .o_valid    (vout),
    .o_data     (dout),
    .o_occupancy(occ)
  );

  typedef struct {
    logic           rst;
    logic           v;
    logic [W-1:0]   d;
    logic [S-1:0]   stall;
    logic [S-1:0]   flush;
    logic           exp_ready;
    logic [S-1:0]   exp_valid;
    logic [S*W-1:0] exp_data;
    logic [2:0]     exp_occ;
  } vec_t;

  localparam int NV = 18;
  vec_t tbl[NV];

  function automatic vec_t mk(input logic r, input logic v, input logic [W-1:0] d,
                              input logic [S-1:0] st, input logic [S-1:0] fl,
                              input logic er, input logic [S-1:0] ev,
                              input logic [S*W-1:0] ed, input logic [2:0] eo);
    vec_t t;
    t.rst = r; t.v = v; t.d = d; t.stall = st; t.flush = fl;
    t.exp_ready = er; t.exp_valid = ev; t.exp_data = ed; t.exp_occ = eo;
    return t;
  endfunction

  task automatic chk(input string name, input logic [S*W-1:0] act, input logic [S*W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Reference model state
  logic         mv[S];
  logic [W-1:0] md[S];

  // Stage k is frozen when some stage j >= k is stalled (and, with bubble
  // collapse, every stage from k up to j holds valid data).
  function automatic logic m_hold(input int k, input logic [S-1:0] st);
    for (int j = k; j < S; j++) begin
      if (st[j]) begin
`ifdef PIPE_REG_CHAIN_BUBBLE_COLLAPSE_EN
        logic all_v = 1'b1;
        for (int m = k; m <= j; m++) all_v &= mv[m];
        if (all_v) return 1'b1;
`else
        return 1'b1;
`endif
      end
    end
    return 1'b0;
  endfunction

  task automatic m_step(input logic r, input logic v, input logic [W-1:0] d,
                        input logic [S-1:0] st, input logic [S-1:0] fl);
    logic         nv[S];
    logic [W-1:0] nd[S];
    logic         h[S];
    for (int k = 0; k < S; k++) h[k] = m_hold(k, st);
    for (int k = 0; k < S; k++) begin
      if (r || fl[k])           begin nv[k] = 0; nd[k] = 0; end
      else if (h[k])            begin nv[k] = mv[k]; nd[k] = md[k]; end
      else if (k == 0)          begin nv[k] = v; nd[k] = v ? d : 0; end
      else if (h[k-1])          begin nv[k] = 0; nd[k] = 0; end
      else                      begin nv[k] = mv[k-1]; nd[k] = md[k-1]; end
    end
    for (int k = 0; k < S; k++) begin mv[k] = nv[k]; md[k] = nd[k]; end
  endtask

  initial begin
    logic [S-1:0]   ev;
    logic [S*W-1:0] ed;
    logic [2:0]     eo;
    logic           r8_ready;

`ifdef PIPE_REG_CHAIN_BUBBLE_COLLAPSE_EN
    r8_ready = 1'b1;
`else
    r8_ready = 1'b0;
`endif
    tbl[0]  = mk(1, 0, 0,     4'b0000, 4'b0000, 1, 4'b0000, {32'h0, 32'h0, 32'h0, 32'h0}, 0);
    tbl[1]  = mk(0, 1, 'h11,  4'b0000, 4'b0000, 1, 4'b0001, {32'h0, 32'h0, 32'h0, 32'h11}, 1);
    tbl[2]  = mk(0, 1, 'h22,  4'b0000, 4'b0000, 1, 4'b0011, {32'h0, 32'h0, 32'h11, 32'h22}, 2);
    tbl[3]  = mk(0, 1, 'h33,  4'b0000, 4'b0000, 1, 4'b0111, {32'h0, 32'h11, 32'h22, 32'h33}, 3);
    tbl[4]  = mk(0, 1, 'h44,  4'b0000, 4'b0000, 1, 4'b1111, {32'h11, 32'h22, 32'h33, 32'h44}, 4);
    tbl[5]  = mk(0, 1, 'h55,  4'b0100, 4'b0000, 0, 4'b0111, {32'h0, 32'h22, 32'h33, 32'h44}, 3);
    tbl[6]  = mk(0, 1, 'h56,  4'b0100, 4'b0000, 0, 4'b0111, {32'h0, 32'h22, 32'h33, 32'h44}, 3);
    tbl[7]  = mk(0, 0, 0,     4'b0000, 4'b0000, 1, 4'b1110, {32'h22, 32'h33, 32'h44, 32'h0}, 3);
    tbl[8]  = mk(1, 1, 'h99,  4'b0010, 4'b0000, r8_ready, 4'b0000, {32'h0, 32'h0, 32'h0, 32'h0}, 0);
    tbl[9]  = mk(0, 1, 'h5A,  4'b0000, 4'b0000, 1, 4'b0001, {32'h0, 32'h0, 32'h0, 32'h5A}, 1);
    tbl[10] = mk(0, 1, 'hB1,  4'b0000, 4'b0000, 1, 4'b0011, {32'h0, 32'h0, 32'h5A, 32'hB1}, 2);
    tbl[11] = mk(0, 1, 'hB2,  4'b0000, 4'b0000, 1, 4'b0111, {32'h0, 32'h5A, 32'hB1, 32'hB2}, 3);
    tbl[12] = mk(0, 1, 'hB3,  4'b0000, 4'b0000, 1, 4'b1111, {32'h5A, 32'hB1, 32'hB2, 32'hB3}, 4);
    tbl[13] = mk(0, 1, 'hC0,  4'b0010, 4'b0010, 0, 4'b1001, {32'hB1, 32'h0, 32'h0, 32'hB3}, 2);
    tbl[14] = mk(0, 1, 'hBB,  4'b0000, 4'b0001, 1, 4'b0010, {32'h0, 32'h0, 32'hB3, 32'h0}, 1);
    tbl[15] = mk(0, 0, 0,     4'b0000, 4'b0000, 1, 4'b0100, {32'h0, 32'hB3, 32'h0, 32'h0}, 1);
    tbl[16] = mk(0, 0, 0,     4'b0000, 4'b0000, 1, 4'b1000, {32'hB3, 32'h0, 32'h0, 32'h0}, 1);
`ifdef PIPE_REG_CHAIN_BUBBLE_COLLAPSE_EN
    tbl[17] = mk(0, 1, 'hAA,  4'b0100, 4'b0000, 1, 4'b0001, {32'h0, 32'h0, 32'h0, 32'hAA}, 1);
`else
    tbl[17] = mk(0, 1, 'hAA,  4'b0100, 4'b0000, 0, 4'b0000, {32'h0, 32'h0, 32'h0, 32'h0}, 0);
`endif

    rst = 1'b0; vin = 1'b0; din = '0; stall = '0; flush = '0;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      rst = tbl[i].rst; vin = tbl[i].v; din = tbl[i].d;
      stall = tbl[i].stall; flush = tbl[i].flush;
      #1;
      chk($sformatf("vec%0d ready", i), {{(S*W-1){1'b0}}, rdy}, {{(S*W-1){1'b0}}, tbl[i].exp_ready});
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d valid", i), {{(S*W-S){1'b0}}, vout}, {{(S*W-S){1'b0}}, tbl[i].exp_valid});
      chk($sformatf("vec%0d data", i), dout, tbl[i].exp_data);
      chk($sformatf("vec%0d occ", i), {{(S*W-3){1'b0}}, occ}, {{(S*W-3){1'b0}}, tbl[i].exp_occ});
    end

    // Randomized traffic; the first cycle is a reset so model and DUT agree.
    for (int i = 0; i < 600; i++) begin
      logic er;
      @(negedge clk);
      rst = (i == 0) || ($urandom_range(0, 59) == 0);
      vin = $urandom_range(0, 3) != 0;
      din = $urandom;
      for (int k = 0; k < S; k++) begin
        stall[k] = $urandom_range(0, 5) == 0;
        flush[k] = $urandom_range(0, 9) == 0;
      end
      #1;
      er = ~m_hold(0, stall);
      if (i != 0) chk("rnd ready", {{(S*W-1){1'b0}}, rdy}, {{(S*W-1){1'b0}}, er});
      m_step(rst, vin, din, stall, flush);
      ev = '0; ed = '0; eo = '0;
      for (int k = 0; k < S; k++) begin
        ev[k] = mv[k];
        ed[k*W +: W] = md[k];
        eo = eo + 3'(mv[k]);
      end
      @(posedge clk);
      #1;
      chk("rnd valid", {{(S*W-S){1'b0}}, vout}, {{(S*W-S){1'b0}}, ev});
      chk("rnd data", dout, ed);
      chk("rnd occ", {{(S*W-3){1'b0}}, occ}, {{(S*W-3){1'b0}}, eo});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pipe_reg_chain.md
Name: pipe_reg_chain

Overview:
- Parametrised chain of STAGES pipeline registers, each carrying a WIDTH-bit payload and a valid bit.
- Supports per-stage stall (hold), per-stage flush (insert bubble), automatic bubble insertion behind a held stage, and upstream backpressure.
- Replaces the hand-written fetch/decode/execute/memory/writeback registers in the core's data pipeline and gives every stage uniform stall/flush.

Parameters:
- WIDTH, 32, payload bits per stage.
- STAGES, 4, number of register stages (minimum 1).

Ports:
- i_clk  input  1  clock; all state updates on its rising edge.
- i_rst  input  1  reset; synchronous, active-high.
- i_valid  input  1  upstream has a payload for stage 0 this cycle.
- i_data  input  WIDTH  payload for stage 0.
- o_ready  output  1  stage 0 accepts i_data/i_valid at this edge; equals ~hold[0].
- i_stall  input  STAGES  bit k requests stage k hold its contents.
- i_flush  input  STAGES  bit k replaces stage k with a bubble.
- o_valid  output  STAGES  bit k is the valid flag of stage k.
- o_data  output  STAGES*WIDTH  slice [k*WIDTH +: WIDTH] is the payload of stage k.
- o_occupancy  output  $clog2(STAGES+1)  number of set bits in o_valid.

Behaviour:
- Reset: when i_rst is 1 at an edge, all o_valid = 0, all o_data = 0, o_occupancy = 0. Reset overrides stall and flush. A mid-stream reset discards all contents in one cycle.
- Outputs are registered. Data entering at stage 0 appears on stage k after k+1 edges when nothing holds.
- Hold chain (combinational, from current state):
  - Top stage: hold[STAGES-1] = i_stall[STAGES-1].
  - Other stages: hold[k] = i_stall[k] | hold[k+1].
  - A stall therefore freezes its own stage and every stage upstream of it.
- Per-stage update at each edge, in priority order:
  1. i_flush[k]: valid[k] <= 0, data[k] <= 0.
  2. Else if hold[k]: valid[k] and data[k] keep their values.
  3. Else if k == 0: valid[0] <= i_valid, data[0] <= (i_valid ? i_data : 0).
  4. Else if hold[k-1]: valid[k] <= 0, data[k] <= 0 (bubble inserted behind the held stage).
  5. Else: valid[k] <= valid[k-1], data[k] <= data[k-1].
- The oldest stage (k = STAGES-1) drains to the consumer every non-held cycle. It has no downstream ready input; the consumer stalls via i_stall.
- Flush and stall on the same stage: flush wins, and the stage becomes a bubble.
  - hold[] is computed from i_stall only, so upstream stages stay frozen that cycle.
- Flush on a stage that is not held still lets upstream data advance into the next stage normally.
- o_ready = 0 while hold[0]; i_data is ignored that cycle and must be re-presented by the producer.
- A bubble never carries non-zero data; this makes waveform comparison deterministic.
- o_occupancy is registered alongside valid: the popcount of the next-state valid vector.

Optional Feature:
- Macro: PIPE_REG_CHAIN_BUBBLE_COLLAPSE_EN.
- With the macro defined, a stall only blocks when its stage holds valid data:
  - blocked[STAGES-1] = valid[STAGES-1] & i_stall[STAGES-1].
  - blocked[k] = valid[k] & (i_stall[k] | blocked[k+1]).
  - hold[k] = blocked[k].
- Result: a stalled empty stage is overwritten and upstream bubbles are squeezed out.
- Without the macro, hold follows the plain chain above, and a stall freezes bubbles as well.

Decomposition:
- Package pipe_pkg:
  - Function for the occupancy width.
  - Constant for the bubble data value (all zeros).
  - typedef of a stage record {valid, data} parametrised through a localparam default of 32.
- Sub-module pipe_stage_reg: one stage's register with flush/hold/load/bubble priority muxing, instantiated STAGES times in a generate loop. The hold chain and occupancy logic stay in the top module.

Test Plan (STAGES=4, WIDTH=32):
- Reset, then stream: stream 0x11,0x22,0x33,0x44 with i_valid=1 and no stall → stage 3 shows 0x11 at edge 4 and 0x44 at edge 7; o_occupancy reaches 4.
- Stall propagation: with stages full (0x44,0x33,0x22,0x11), i_stall=4'b0100 for 2 cycles →
  - Stages 0..2 frozen and o_ready=0.
  - Stage 3 loads a bubble: valid=0, data=0.
  - After release, 0x22 reaches stage 3 on the next edge.
- Flush beats stall: full pipe, i_stall[1]=1 and i_flush[1]=1 together → stage 1 becomes valid=0, data=0; stage 0 is held at its value.
- Reset mid-stream: 3 valid entries plus an active stall, assert i_rst for 1 cycle → all o_valid=0, o_data=0, o_occupancy=0 on the next edge. The first push after reset appears at stage 0 one edge later.
- Bubble collapse: with PIPE_REG_CHAIN_BUBBLE_COLLAPSE_EN, stage 2 empty, i_stall=4'b0100, i_data=0xAA →
  - Data advances into stage 2 and o_ready stays 1.
  - Without the macro, o_ready=0 and 0xAA is not accepted.
- Flush without hold: flush stage 0 while 0xBB sits in stage 0 and no stall → 0xBB is discarded, and stage 1 receives the bubble on the following edge.
